// File: rtl/xnor_parity_pkg.sv
// rtl/xnor_parity_pkg.sv - shared FSM state type and serial line levels for xnor_parity_tx
//
// Purpose: state encoding for the frame transmitter FSM and the fixed line
// levels used for idle, start and stop bits.
// Ports: none (package).
package xnor_parity_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } tx_state_t;

    localparam logic IDLE_LEVEL  = 1'b1;
    localparam logic START_LEVEL = 1'b0;
    localparam logic STOP_LEVEL  = 1'b1;

endpackage

// File: rtl/xnor_parity_tx_parity_gen.sv
// rtl/xnor_parity_tx_parity_gen.sv - combinational parity bit generator
//
// Purpose: produces the parity bit for a data word so the receive-side XNOR
// check passes.
// Ports:
//   data_i   [DATA_W]  word to protect
//   parity_o [1]       ~^data_i when ODD_PARITY, else ^data_i
module parity_gen #(
    parameter int DATA_W     = 8,
    parameter bit ODD_PARITY = 1'b1
) (
    input  logic [DATA_W-1:0] data_i,
    output logic              parity_o
);

    // Odd mode: data plus parity carries an odd number of ones.
    assign parity_o = ODD_PARITY ? ~^data_i : ^data_i;

endmodule

// File: rtl/xnor_parity_tx.sv
// rtl/xnor_parity_tx.sv - serial frame transmitter: start, data LSB first, parity, stop
//
// Purpose: accepts a word on a valid/ready handshake and shifts it out one bit
// per clock as a DATA_W+3 bit frame.
// Ports:
//   clk       clock, all state on posedge
//   rst       synchronous reset, active-high
//   in_valid  in_data is valid this cycle
//   in_ready  block can accept a word (decoded from state, IDLE or STOP)
//   in_data   [DATA_W] word, sampled only on accept
//   tx_bit    serial line, idles high (registered)
//   tx_frame  high during every frame bit (registered)
//   tx_done   one-cycle pulse in the stop-bit cycle (registered)
module xnor_parity_tx
    import xnor_parity_pkg::*;
#(
    parameter int DATA_W     = 8,
    parameter bit ODD_PARITY = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              tx_bit,
    output logic              tx_frame,
    output logic              tx_done
);

    localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);

    tx_state_t         state_q, state_d;
    logic [DATA_W-1:0] shift_q, shift_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              parity_q, parity_d;
    logic              tx_bit_q, tx_bit_d;
    logic              frame_q, frame_d;
    logic              done_q, done_d;
    logic              in_parity;
    logic              accept;

    // Parity is taken from the word at the accept edge and held, so later
    // changes on in_data cannot reach the frame in flight.
    parity_gen #(
        .DATA_W     (DATA_W),
        .ODD_PARITY (ODD_PARITY)
    ) u_parity_gen (
        .data_i   (in_data),
        .parity_o (in_parity)
    );

    assign in_ready = (state_q == IDLE) || (state_q == STOP);
    assign accept   = in_valid && in_ready;

    // Outputs are registered: each transition loads the line level that the
    // destination state drives, so tx_bit always matches the current state.
    always_comb begin
        state_d  = state_q;
        shift_d  = shift_q;
        cnt_d    = cnt_q;
        parity_d = parity_q;
        tx_bit_d = tx_bit_q;
        frame_d  = frame_q;
        done_d   = 1'b0;
        case (state_q)
            IDLE, STOP: begin
                if (accept) begin
                    state_d  = START;
                    shift_d  = in_data;
                    parity_d = in_parity;
                    tx_bit_d = START_LEVEL;
                    frame_d  = 1'b1;
                end else begin
                    state_d  = IDLE;
                    tx_bit_d = IDLE_LEVEL;
                    frame_d  = 1'b0;
                end
            end
            START: begin
                state_d  = DATA;
                cnt_d    = '0;
                tx_bit_d = shift_q[0];
                shift_d  = shift_q >> 1;
            end
            DATA: begin
                if (cnt_q == CNT_LAST) begin
                    state_d  = PARITY;
                    tx_bit_d = parity_q;
                end else begin
                    cnt_d    = cnt_q + 1'b1;
                    tx_bit_d = shift_q[0];
                    shift_d  = shift_q >> 1;
                end
            end
            PARITY: begin
                state_d  = STOP;
                tx_bit_d = STOP_LEVEL;
                done_d   = 1'b1;
            end
            default: begin
                state_d  = IDLE;
                tx_bit_d = IDLE_LEVEL;
                frame_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            shift_q  <= '0;
            cnt_q    <= '0;
            parity_q <= 1'b0;
            tx_bit_q <= IDLE_LEVEL;
            frame_q  <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            shift_q  <= shift_d;
            cnt_q    <= cnt_d;
            parity_q <= parity_d;
            tx_bit_q <= tx_bit_d;
            frame_q  <= frame_d;
            done_q   <= done_d;
        end
    end

    assign tx_bit   = tx_bit_q;
    assign tx_frame = frame_q;
    assign tx_done  = done_q;

endmodule
